// File: rtl/perf_uart_reporter.sv
// perf_uart_reporter: sends "CYC=XXXXXXXX\r\n" over UART TX whenever
// measurement_done_i rises. The 32-bit count is captured on that edge.
// Ports: clk_i, reset_ni (async, active-low), cycle_count_i[31:0],
//   measurement_done_i, uart_tx_o, busy_o, report_done_o.
// Option: define PERF_UART_PARITY_EN for 8E1 framing (default 8N1).
module perf_uart_reporter #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] cycle_count_i,
  input  logic        measurement_done_i,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        report_done_o
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef PERF_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [3:0]    idx_q;
  logic [31:0]   cap_q;
  logic [7:0]    shf_q;
  logic          prev_q;
`ifdef PERF_UART_PARITY_EN
  logic          par_q;
`endif

  logic trig;
  logic bit_end;
  logic can_start;
  logic in_bit;

  assign trig      = measurement_done_i & ~prev_q;
  assign bit_end   = (baud_q == CW'(CPB - 1));
  assign can_start = (state_q == S_IDLE) ||
                     (state_q == S_FINISH);
  assign in_bit    = (state_q == S_START) ||
                     (state_q == S_DATA) ||
`ifdef PERF_UART_PARITY_EN
                     (state_q == S_PARITY) ||
`endif
                     (state_q == S_STOP);

  function automatic logic [7:0] hex_ch(
    input logic [3:0] n
  );
    if (n < 4'd10) hex_ch = 8'h30 + {4'h0, n};
    else           hex_ch = 8'h37 + {4'h0, n};
  endfunction

  // Bytes 4..11 are the nibbles of c, MSB nibble first.
  function automatic logic [7:0] msg_byte(
    input logic [3:0]  i,
    input logic [31:0] c
  );
    logic [3:0] n;
    int         sh;
    sh = (11 - int'(i)) * 4;
    n  = 4'(c >> sh);
    case (i)
      4'd0:    msg_byte = 8'h43;
      4'd1:    msg_byte = 8'h59;
      4'd2:    msg_byte = 8'h43;
      4'd3:    msg_byte = 8'h3D;
      4'd12:   msg_byte = 8'h0D;
      4'd13:   msg_byte = 8'h0A;
      default: msg_byte = hex_ch(n);
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (trig) state_d = S_LOAD;
      S_LOAD:
        state_d = S_START;
      S_START:
        if (bit_end) state_d = S_DATA;
      S_DATA:
        if (bit_end && bit_q == 3'd7)
`ifdef PERF_UART_PARITY_EN
          state_d = S_PARITY;
      S_PARITY:
        if (bit_end)
`endif
          state_d = S_STOP;
      S_STOP:
        if (bit_end)
          state_d = (idx_q == 4'd13) ? S_FINISH
                                     : S_LOAD;
      S_FINISH:
        state_d = trig ? S_LOAD : S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      prev_q <= 1'b0;
      baud_q <= '0;
      bit_q  <= '0;
      idx_q  <= '0;
      cap_q  <= '0;
      shf_q  <= '0;
`ifdef PERF_UART_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      prev_q <= measurement_done_i;
      if (in_bit)
        baud_q <= bit_end ? '0 : baud_q + 1'b1;
      else
        baud_q <= '0;
      if (can_start && trig) begin
        cap_q <= cycle_count_i;
        idx_q <= '0;
      end
      if (state_q == S_LOAD) begin
        shf_q <= msg_byte(idx_q, cap_q);
        bit_q <= '0;
`ifdef PERF_UART_PARITY_EN
        par_q <= ^msg_byte(idx_q, cap_q);
`endif
      end
      if (state_q == S_DATA && bit_end) begin
        shf_q <= shf_q >> 1;
        bit_q <= bit_q + 3'd1;
      end
      if (state_q == S_STOP && bit_end)
        idx_q <= idx_q + 4'd1;
    end
  end

  // Decoded from state so reset forces the line idle at once.
  always_comb begin
    uart_tx_o = 1'b1;
    unique case (state_q)
      S_START:  uart_tx_o = 1'b0;
      S_DATA:   uart_tx_o = shf_q[0];
`ifdef PERF_UART_PARITY_EN
      S_PARITY: uart_tx_o = par_q;
`endif
      default:  uart_tx_o = 1'b1;
    endcase
  end

  assign busy_o        = !can_start;
  assign report_done_o = (state_q == S_FINISH);

endmodule
